// File: rtl/conv_relu_pool_stream_if.sv
// Handshake bundle between the conv post-processing stage and its neighbours.
// Signal names are given from the stage's point of view: i_* are driven by
// the surroundings, o_* are driven by the stage.
interface conv_relu_pool_stream_if #(
  parameter int DW = 32
);
  logic                 i_valid;
  logic                 o_ready;
  logic signed [DW-1:0] i_data;
  logic                 o_valid;
  logic                 i_ready;
  logic signed [DW-1:0] o_data;

  // Upstream producer plus downstream consumer (the environment around the stage)
  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data
  );

  // The post-processing stage itself
  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data
  );
endinterface

// File: rtl/conv_relu_pool_stream.sv
// Streaming ReLU + non-overlapping max-pool stage behind the convolution PE.
// Consumes a row-major OUT_SIZE x OUT_SIZE frame, keeps one line of partial
// window maxima, and hands results to the downstream writer through a small
// output FIFO so that it can apply backpressure.
module conv_relu_pool_stream #(
  parameter int DW          = 32,
  parameter int OUT_SIZE    = 6,
  parameter int POOL        = 2,
  parameter int RELU_EN     = 1,
  parameter int MAXPOOL     = 1,
  parameter int OFIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_go,
  conv_relu_pool_stream_if.slave        bus,
  output logic                          o_busy,
  output logic                          o_done
);

  localparam int NP    = OUT_SIZE / POOL;
  localparam int TOTAL = OUT_SIZE * OUT_SIZE;
  localparam int CW    = $clog2(OUT_SIZE);
  localparam int TW    = $clog2(TOTAL);
  localparam int PW    = $clog2(NP + 1);
  localparam int QW    = $clog2(POOL);
  localparam int PIW   = (NP > 1) ? $clog2(NP) : 1;
  localparam int AW    = $clog2(OFIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Position inside the frame: column, position inside the pooling window
  // (cr/rr) and which window column / window row we are in (pc/rb).
  logic [CW-1:0] col_q, col_d;
  logic [TW-1:0] acc_q, acc_d;
  logic [QW-1:0] cr_q, cr_d;
  logic [QW-1:0] rr_q, rr_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [PW-1:0] rb_q, rb_d;

  logic signed [DW-1:0] pbuf_q [NP];

  logic signed [DW-1:0] fifoMem_q [OFIFO_DEPTH];
  logic [AW-1:0]        wrPtr_q, rdPtr_q;
  logic [AW:0]          fifoCnt_q;

  logic                 accept, pop, push;
  logic                 fifoFull;
  logic                 inWin, firstInWin, lastInWin;
  logic [PIW-1:0]       pIdx;
  logic signed [DW-1:0] reluX, pbufCur, winMax, pushData;

  assign fifoFull    = (fifoCnt_q == (AW+1)'(OFIFO_DEPTH));
  assign bus.o_ready = (state_q == S_RUN) && !fifoFull;
  assign bus.o_valid = (fifoCnt_q != '0);
  assign bus.o_data  = fifoMem_q[rdPtr_q];
  assign accept      = bus.i_valid && bus.o_ready;
  assign pop         = bus.o_valid && bus.i_ready;

  assign reluX      = ((RELU_EN != 0) && bus.i_data[DW-1]) ? '0 : bus.i_data;
  assign inWin      = (pc_q < PW'(NP)) && (rb_q < PW'(NP));
  assign firstInWin = (cr_q == '0) && (rr_q == '0);
  assign lastInWin  = (cr_q == QW'(POOL-1)) && (rr_q == QW'(POOL-1));
  assign pIdx       = inWin ? PIW'(pc_q) : '0;
  assign pbufCur    = pbuf_q[pIdx];
  assign winMax     = (reluX > pbufCur) ? reluX : pbufCur;

  // Decide whether the accepted element produces an output and which value
  always_comb begin
    push     = 1'b0;
    pushData = reluX;
    if (accept) begin
      if (MAXPOOL == 0) begin
        push = 1'b1;
      end else if (inWin && lastInWin) begin
        push     = 1'b1;
        pushData = winMax;
      end
    end
  end

  // Advance the frame position counters on every accept; a start clears them
  always_comb begin
    col_d = col_q;
    acc_d = acc_q;
    cr_d  = cr_q;
    rr_d  = rr_q;
    pc_d  = pc_q;
    rb_d  = rb_q;
    if ((state_q == S_IDLE) && i_go) begin
      col_d = '0;
      acc_d = '0;
      cr_d  = '0;
      rr_d  = '0;
      pc_d  = '0;
      rb_d  = '0;
    end else if (accept) begin
      acc_d = acc_q + 1'b1;
      if (col_q == CW'(OUT_SIZE-1)) begin
        col_d = '0;
        cr_d  = '0;
        pc_d  = '0;
        if (rr_q == QW'(POOL-1)) begin
          rr_d = '0;
          rb_d = rb_q + 1'b1;
        end else begin
          rr_d = rr_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
        if (cr_q == QW'(POOL-1)) begin
          cr_d = '0;
          pc_d = pc_q + 1'b1;
        end else begin
          cr_d = cr_q + 1'b1;
        end
      end
    end
  end

  // Frame sequencing and the status outputs that follow from the state
  always_comb begin
    state_d = state_q;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_go) state_d = S_RUN;
      end
      S_RUN: begin
        o_busy = 1'b1;
        if (accept && (acc_q == TW'(TOTAL-1))) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        o_busy = 1'b1;
        if (fifoCnt_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and position registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      acc_q   <= '0;
      cr_q    <= '0;
      rr_q    <= '0;
      pc_q    <= '0;
      rb_q    <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      acc_q   <= acc_d;
      cr_q    <= cr_d;
      rr_q    <= rr_d;
      pc_q    <= pc_d;
      rb_q    <= rb_d;
    end
  end

  // Partial window maxima: seed on the window's first element, fold in the rest,
  // leave untouched on the closing element since that one goes straight out
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NP; i++) pbuf_q[i] <= '0;
    end else if (accept && (MAXPOOL != 0) && inWin && !lastInWin) begin
      pbuf_q[pIdx] <= firstInWin ? reluX : winMax;
    end
  end

  // Output FIFO; accepts are gated on !full so a push never meets a full FIFO
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      fifoCnt_q <= '0;
      for (int i = 0; i < OFIFO_DEPTH; i++) fifoMem_q[i] <= '0;
    end else begin
      if (push) begin
        fifoMem_q[wrPtr_q] <= pushData;
        wrPtr_q            <= wrPtr_q + 1'b1;
      end
      if (pop) rdPtr_q <= rdPtr_q + 1'b1;
      case ({push, pop})
        2'b10:   fifoCnt_q <= fifoCnt_q + 1'b1;
        2'b01:   fifoCnt_q <= fifoCnt_q - 1'b1;
        default: fifoCnt_q <= fifoCnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_relu_pool_stream.sv
// Bench for conv_relu_pool_stream: four instances cover the default pooled
// configuration, ReLU bypass, pooling bypass and a frame size that leaves a
// discarded edge column/row. Expected results come from a 2-D window model.
module tb_conv_relu_pool_stream;

  localparam int DW   = 32;
  localparam int POOL = 2;
  localparam int NDUT = 4;

  typedef struct {
    int dut;
    int pattern;
    int stall;
    int expCount;
    int expFirst;
    int expSum;
  } vec_t;

  logic clk;
  logic rst;

  logic                 goS   [NDUT];
  logic                 vldS  [NDUT];
  logic                 rdyS  [NDUT];
  logic signed [DW-1:0] datS  [NDUT];
  logic                 oRdy  [NDUT];
  logic                 oVld  [NDUT];
  logic signed [DW-1:0] oDat  [NDUT];
  logic                 busyS [NDUT];
  logic                 doneS [NDUT];

  int cfgSize [NDUT] = '{6, 6, 6, 5};
  int cfgRelu [NDUT] = '{1, 0, 1, 1};
  int cfgPool [NDUT] = '{1, 1, 0, 1};

  int stimQ[$];
  int expQ[$];
  int gotQ[$];
  int checks;
  int errors;
  int lastStallAcc;

  conv_relu_pool_stream_if #(.DW(DW)) bus0 ();
  conv_relu_pool_stream_if #(.DW(DW)) bus1 ();
  conv_relu_pool_stream_if #(.DW(DW)) bus2 ();
  conv_relu_pool_stream_if #(.DW(DW)) bus3 ();

  assign bus0.i_valid = vldS[0];
  assign bus0.i_data  = datS[0];
  assign bus0.i_ready = rdyS[0];
  assign oRdy[0]      = bus0.o_ready;
  assign oVld[0]      = bus0.o_valid;
  assign oDat[0]      = bus0.o_data;

  assign bus1.i_valid = vldS[1];
  assign bus1.i_data  = datS[1];
  assign bus1.i_ready = rdyS[1];
  assign oRdy[1]      = bus1.o_ready;
  assign oVld[1]      = bus1.o_valid;
  assign oDat[1]      = bus1.o_data;

  assign bus2.i_valid = vldS[2];
  assign bus2.i_data  = datS[2];
  assign bus2.i_ready = rdyS[2];
  assign oRdy[2]      = bus2.o_ready;
  assign oVld[2]      = bus2.o_valid;
  assign oDat[2]      = bus2.o_data;

  assign bus3.i_valid = vldS[3];
  assign bus3.i_data  = datS[3];
  assign bus3.i_ready = rdyS[3];
  assign oRdy[3]      = bus3.o_ready;
  assign oVld[3]      = bus3.o_valid;
  assign oDat[3]      = bus3.o_data;

  conv_relu_pool_stream #(.DW(DW), .OUT_SIZE(6), .POOL(POOL), .RELU_EN(1), .MAXPOOL(1), .OFIFO_DEPTH(4))
    u0 (.i_clk(clk), .i_rst(rst), .i_go(goS[0]), .bus(bus0), .o_busy(busyS[0]), .o_done(doneS[0]));
  conv_relu_pool_stream #(.DW(DW), .OUT_SIZE(6), .POOL(POOL), .RELU_EN(0), .MAXPOOL(1), .OFIFO_DEPTH(4))
    u1 (.i_clk(clk), .i_rst(rst), .i_go(goS[1]), .bus(bus1), .o_busy(busyS[1]), .o_done(doneS[1]));
  conv_relu_pool_stream #(.DW(DW), .OUT_SIZE(6), .POOL(POOL), .RELU_EN(1), .MAXPOOL(0), .OFIFO_DEPTH(4))
    u2 (.i_clk(clk), .i_rst(rst), .i_go(goS[2]), .bus(bus2), .o_busy(busyS[2]), .o_done(doneS[2]));
  conv_relu_pool_stream #(.DW(DW), .OUT_SIZE(5), .POOL(POOL), .RELU_EN(1), .MAXPOOL(1), .OFIFO_DEPTH(4))
    u3 (.i_clk(clk), .i_rst(rst), .i_go(goS[3]), .bus(bus3), .o_busy(busyS[3]), .o_done(doneS[3]));

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int k, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s dut%0d: got %0d, expected %0d", name, k, actual, expected);
    end
  endtask

  // Build one input frame: 0 ramp, 1 constant -5, 2 alternating +3/-3, 3 random
  task automatic fillPattern(input int k, input int pat);
    int n;
    n = cfgSize[k];
    stimQ = {};
    for (int i = 0; i < n * n; i++) begin
      case (pat)
        0:       stimQ.push_back(i);
        1:       stimQ.push_back(-5);
        2:       stimQ.push_back((i % 2 == 0) ? 3 : -3);
        default: stimQ.push_back(int'($urandom_range(0, 100)) - 50);
      endcase
    end
  endtask

  // Reference: rectify the frame, then take the max of every complete window
  task automatic modelFrame(input int k);
    int n;
    int np;
    int m;
    int idx;
    int v[$];
    n  = cfgSize[k];
    np = n / POOL;
    v = {};
    expQ = {};
    foreach (stimQ[i]) v.push_back((cfgRelu[k] != 0 && stimQ[i] < 0) ? 0 : stimQ[i]);
    if (cfgPool[k] == 0) begin
      expQ = v;
    end else begin
      for (int pr = 0; pr < np; pr++) begin
        for (int pc = 0; pc < np; pc++) begin
          m = v[(POOL * pr) * n + POOL * pc];
          for (int dr = 0; dr < POOL; dr++) begin
            for (int dc = 0; dc < POOL; dc++) begin
              idx = (POOL * pr + dr) * n + POOL * pc + dc;
              if (v[idx] > m) m = v[idx];
            end
          end
          expQ.push_back(m);
        end
      end
    end
  endtask

  // Run one whole frame on DUT k with stimQ, holding i_ready low for 'stall'
  // cycles after go; randHs randomises both valid and ready
  task automatic applyStimulus(input int k, input int stall, input bit randHs);
    int idx;
    int cyc;
    int doneCnt;
    int stallAcc;
    int act;
    idx = 0;
    cyc = 0;
    doneCnt = 0;
    stallAcc = 0;
    modelFrame(k);
    gotQ = {};
    goS[k] = 1'b1;
    @(posedge clk); #1;
    goS[k] = 1'b0;
    while (cyc < 3000 && doneCnt == 0) begin
      vldS[k] = (idx < stimQ.size()) && (randHs ? ($urandom_range(0, 3) != 0) : 1'b1);
      datS[k] = (idx < stimQ.size()) ? stimQ[idx] : 0;
      rdyS[k] = (cyc < stall) ? 1'b0 : (randHs ? ($urandom_range(0, 3) != 0) : 1'b1);
      if (doneS[k]) begin
        doneCnt++;
        checkOutput("transfersBeforeDone", k, gotQ.size(), expQ.size());
      end
      if (vldS[k] && oRdy[k]) begin
        idx++;
        if (cyc < stall) stallAcc++;
      end
      if (oVld[k] && rdyS[k]) gotQ.push_back(oDat[k]);
      @(posedge clk); #1;
      cyc++;
    end
    vldS[k] = 1'b0;
    rdyS[k] = 1'b0;
    checkOutput("doneSeen", k, doneCnt, 1);
    checkOutput("inputsAccepted", k, idx, stimQ.size());
    checkOutput("outputCount", k, gotQ.size(), expQ.size());
    foreach (expQ[i]) begin
      act = (i < gotQ.size()) ? gotQ[i] : 2147483647;
      checkOutput("outputValue", k, act, expQ[i]);
    end
    @(posedge clk); #1;
    checkOutput("doneOneCycle", k, int'(doneS[k]), 0);
    checkOutput("busyAfterDone", k, int'(busyS[k]), 0);
    checkOutput("readyInIdle", k, int'(oRdy[k]), 0);
    lastStallAcc = stallAcc;
  endtask

  initial begin
    vec_t vecs[6];
    int sum;
    int acc;
    int doneSeen;
    int waitCyc;

    checks = 0;
    errors = 0;
    lastStallAcc = 0;
    for (int k = 0; k < NDUT; k++) begin
      goS[k] = 1'b0;
      vldS[k] = 1'b0;
      rdyS[k] = 1'b0;
      datS[k] = '0;
    end

    vecs[0] = '{dut: 0, pattern: 0, stall: 0,  expCount: 9,  expFirst: 7,  expSum: 189};
    vecs[1] = '{dut: 0, pattern: 1, stall: 0,  expCount: 9,  expFirst: 0,  expSum: 0};
    vecs[2] = '{dut: 1, pattern: 1, stall: 0,  expCount: 9,  expFirst: -5, expSum: -45};
    vecs[3] = '{dut: 0, pattern: 0, stall: 20, expCount: 9,  expFirst: 7,  expSum: 189};
    vecs[4] = '{dut: 2, pattern: 2, stall: 0,  expCount: 36, expFirst: 3,  expSum: 54};
    vecs[5] = '{dut: 3, pattern: 0, stall: 0,  expCount: 4,  expFirst: 6,  expSum: 48};

    // Reset state, with i_valid raised to show it is ignored in IDLE
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      checkOutput("rstReady", k, int'(oRdy[k]), 0);
      checkOutput("rstValid", k, int'(oVld[k]), 0);
      checkOutput("rstData", k, int'(oDat[k]), 0);
      checkOutput("rstBusy", k, int'(busyS[k]), 0);
      checkOutput("rstDone", k, int'(doneS[k]), 0);
    end
    rst = 1'b0;
    vldS[0] = 1'b1;
    datS[0] = 123;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idleReady", 0, int'(oRdy[0]), 0);
    checkOutput("idleValid", 0, int'(oVld[0]), 0);
    vldS[0] = 1'b0;

    // Directed frames from the table
    for (int v = 0; v < 6; v++) begin
      fillPattern(vecs[v].dut, vecs[v].pattern);
      applyStimulus(vecs[v].dut, vecs[v].stall, 1'b0);
      checkOutput("tblCount", vecs[v].dut, gotQ.size(), vecs[v].expCount);
      checkOutput("tblFirst", vecs[v].dut, (gotQ.size() > 0) ? gotQ[0] : 2147483647, vecs[v].expFirst);
      sum = 0;
      foreach (gotQ[i]) sum += gotQ[i];
      checkOutput("tblSum", vecs[v].dut, sum, vecs[v].expSum);
    end

    // Long stall: input stops exactly when the 4-deep FIFO fills (4th pooled result at element 19)
    fillPattern(0, 0);
    applyStimulus(0, 30, 1'b0);
    checkOutput("acceptsUntilFull", 0, lastStallAcc, 20);

    // Abort a frame after 10 accepts, with two results still queued
    fillPattern(0, 0);
    doneSeen = 0;
    acc = 0;
    waitCyc = 0;
    goS[0] = 1'b1;
    @(posedge clk); #1;
    goS[0] = 1'b0;
    while (acc < 10 && waitCyc < 100) begin
      vldS[0] = 1'b1;
      datS[0] = stimQ[acc];
      if (doneS[0]) doneSeen++;
      if (oRdy[0]) acc++;
      @(posedge clk); #1;
      waitCyc++;
    end
    vldS[0] = 1'b0;
    checkOutput("abortAccepts", 0, acc, 10);
    checkOutput("abortQueued", 0, int'(oVld[0]), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abortValid", 0, int'(oVld[0]), 0);
    checkOutput("abortBusy", 0, int'(busyS[0]), 0);
    checkOutput("abortData", 0, int'(oDat[0]), 0);
    repeat (5) begin
      if (doneS[0]) doneSeen++;
      @(posedge clk); #1;
    end
    checkOutput("abortNoDone", 0, doneSeen, 0);
    applyStimulus(0, 0, 1'b0);
    checkOutput("freshFirst", 0, (gotQ.size() > 0) ? gotQ[0] : 2147483647, 7);

    // Random frames with random handshakes on every configuration
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < NDUT; k++) begin
        fillPattern(k, 3);
        applyStimulus(k, int'($urandom_range(0, 8)), 1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_relu_pool_stream.md
Name: conv_relu_pool_stream

Overview:
Streaming post-processing stage behind the convolution PE. It applies optional ReLU and optional non-overlapping POOL x POOL max-pooling to a row-major stream of OUT_SIZE x OUT_SIZE conv results. Max-pooling uses a single line of partial maxima, not a full-frame array. It exposes valid/ready handshakes on both sides through an output FIFO, so the downstream BRAM writer can apply backpressure.

Parameters:
DW, 32, data width of conv results (signed two's complement)
OUT_SIZE, 6, conv output height/width in elements (>= POOL)
POOL, 2, pooling window size and stride (>= 2)
RELU_EN, 1, 1 = clamp negatives to 0 before pooling; 0 = bypass
MAXPOOL, 1, 1 = pool; 0 = pass every element through
OFIFO_DEPTH, 4, output FIFO depth (power of 2, >= 2)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_go  in  1  start-of-frame pulse, sampled only in IDLE
i_valid  in  1  input element valid
o_ready  out  1  block accepts input this cycle
i_data  in  DW  signed conv result
o_valid  out  1  o_data valid
i_ready  in  1  downstream accepts o_data
o_data  out  DW  signed result (ReLU/pooled)
o_busy  out  1  high in RUN and DRAIN
o_done  out  1  one-cycle pulse at frame completion

Behaviour:
- Reset: state IDLE. All outputs are 0 (o_ready, o_valid, o_data, o_busy, o_done). FIFO is emptied, all counters are 0, and partial-max buffer entries are 0. This applies equally to reset mid-frame, which abandons the frame with no o_done.
- Accept = i_valid && o_ready. Transfer out = o_valid && i_ready. o_valid = FIFO non-empty. o_data = FIFO head, registered output.
- FSM, IDLE:
  - o_ready = 0.
  - i_valid is ignored; there is no error.
  - i_go goes to RUN and clears the column counter col, row counter row, and accepted count.
- FSM, RUN:
  - o_ready = !fifo_full.
  - Each accept advances col; at col = OUT_SIZE-1 it wraps to 0 and row increments.
  - On the OUT_SIZE^2-th accept, go to DRAIN.
  - i_go is ignored.
- FSM, DRAIN:
  - o_ready = 0.
  - When the FIFO is empty and no push is pending, go to DONE.
- FSM, DONE:
  - o_done = 1 for exactly one cycle, then go to IDLE. o_busy = 0.
- ReLU: x = (RELU_EN && i_data < 0) ? 0 : i_data. Width stays DW.
- MAXPOOL = 0: every accepted x is pushed to the FIFO on the accepting edge.
- MAXPOOL = 1, using pc = col / POOL, cr = col % POOL, rr = row % POOL, NP = OUT_SIZE / POOL:
  - Discard: elements with col >= NP*POOL or row >= NP*POOL are accepted and discarded (floor semantics, no partial windows).
  - rr == 0 && cr == 0: pbuf[pc] <= x.
  - Otherwise: pbuf[pc] <= signed max(pbuf[pc], x).
  - rr == POOL-1 && cr == POOL-1: push max(pbuf[pc], x) to the FIFO on the same edge; pbuf[pc] is not updated.
  - pbuf has NP entries.
- Output count per frame: MAXPOOL ? NP^2 : OUT_SIZE^2, in row-major order of the pooled grid.
- Latency: a pushed value appears on o_valid the cycle after the push if the FIFO was empty.
- Simultaneous push and pop: a push while the FIFO is full is impossible by construction, because o_ready gates accepts on !fifo_full. Simultaneous push and pop is legal, and the count is unchanged.
- Ties in max: either operand (equal values).
- Throughput: 1 accept per cycle with i_ready held high; no bubbles between rows or pool windows.
- Only one frame is in flight at a time. A new i_go is honoured only in IDLE, i.e. from the cycle after the o_done pulse.

Test Plan:
- Ramp, OUT_SIZE=6, POOL=2, RELU_EN=1, i_data = 0..35 row-major, i_valid and i_ready held 1 -> outputs 7, 9, 11, 19, 21, 23, 31, 33, 35; o_done pulses once after the 9th transfer; o_busy low after.
- All-negative frame (i_data = -5), RELU_EN=1 -> nine outputs of 0. With RELU_EN=0 -> nine outputs of -5, confirming signed max.
- Backpressure: same ramp, i_ready low for 20 cycles after go -> o_ready drops after OFIFO_DEPTH (4) pushes. When i_ready resumes, all 9 values arrive in order with no loss or duplication.
- MAXPOOL=0, RELU_EN=1, input alternating +3/-3 over 36 elements -> 36 outputs alternating 3/0; o_done after the 36th transfer.
- OUT_SIZE=5, POOL=2, ramp 0..24 -> outputs 6, 8, 16, 18; column 4 and row 4 are discarded; all 25 inputs are accepted.
- Reset mid-frame after 10 accepts, then a fresh i_go with the ramp -> first output 7, no stale partial max; no o_done for the aborted frame.
